// File: rtl/dmem_controller_pkg.sv
// Shared encodings and helpers for the data-memory controller.
package dmem_controller_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] BE_WORD = 4'hF;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_controller_lane_format.sv
// Byte-lane formatting: byte enables, store-byte replication, load-lane extraction.
module dmem_controller_lane_format
    import dmem_controller_pkg::*;
(
    input  logic        i_byte,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0] w_lane_byte;

    always_comb begin
        w_lane_byte = i_rdata[7:0];
        case (i_lane)
            2'd1:    w_lane_byte = i_rdata[15:8];
            2'd2:    w_lane_byte = i_rdata[23:16];
            2'd3:    w_lane_byte = i_rdata[31:24];
            default: w_lane_byte = i_rdata[7:0];
        endcase
    end

    assign o_be    = i_byte ? (4'b0001 << i_lane) : BE_WORD;
    assign o_wdata = i_byte ? {4{i_wdata[7:0]}} : i_wdata;
    assign o_rdata = i_byte ? {24'h0, w_lane_byte} : i_rdata;

endmodule

// File: rtl/dmem_controller.sv
// Memory-stage load/store controller: runs one access on the req/ack bus and
// stalls the pipeline until the access completes, times out, or is rejected.
//
// state  | meaning
// IDLE   | no access open; accepts a command and stalls in the same cycle
// REQ    | bus request open; waits for mem_ack or timeout
// DONE   | one-cycle release of stall; returns read_data / error
module dmem_controller
    import dmem_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 7
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_read_cmd,
    input  logic        i_write_cmd,
    input  logic        i_byte_access,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_stall,
    output logic        o_error,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]           r_state;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 r_byte;
    logic                 r_we;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic        w_cmd;
    logic        w_illegal;
    logic        w_in_req;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_fmt;
    logic [31:0] w_rdata_fmt;

    assign w_cmd     = i_read_cmd | i_write_cmd;
    assign w_illegal = (i_read_cmd & i_write_cmd) |
                       (~i_byte_access & (i_address[1:0] != 2'b00));
    assign w_in_req  = (r_state == S_REQ);

    dmem_controller_lane_format u_lane_format (
        .i_byte  (r_byte),
        .i_lane  (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (i_mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata_fmt),
        .o_rdata (w_rdata_fmt)
    );

    // Timeout is a down-counter loaded on accept; zero in REQ means the window is spent.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_byte  <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd) begin
                        r_addr  <= i_address;
                        r_wdata <= i_write_data;
                        r_byte  <= i_byte_access;
                        r_we    <= i_write_cmd;
                        r_rdata <= '0;
                        r_cnt   <= CNT_LOAD;
                        r_err   <= w_illegal;
                        r_state <= w_illegal ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_ack) begin
                        r_rdata <= r_we ? 32'h0 : w_rdata_fmt;
                        r_state <= S_DONE;
                    end else if (r_cnt == '0) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset gates stall directly so a command held through reset cannot freeze the pipe.
    assign o_stall     = ~i_rst & (((r_state == S_IDLE) & w_cmd) | w_in_req);
    assign o_error     = (r_state == S_DONE) & r_err;
    assign o_read_data = r_rdata;
    assign o_mem_req   = w_in_req;
    assign o_mem_we    = w_in_req & r_we;
    assign o_mem_addr  = w_in_req ? word_align(r_addr) : 32'h0;
    assign o_mem_be    = w_in_req ? w_be : 4'h0;
    assign o_mem_wdata = w_in_req ? w_wdata_fmt : 32'h0;

endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench for dmem_controller: per-cycle transaction model plus literal pins.
module tb_dmem_controller;

    localparam int TMO = 64;

    logic        clk;
    logic        rst;
    logic        read_cmd, write_cmd, byte_acc;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        stall, error;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    dmem_controller dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_read_cmd    (read_cmd),
        .i_write_cmd   (write_cmd),
        .i_byte_access (byte_acc),
        .i_address     (address),
        .i_write_data  (write_data),
        .o_read_data   (read_data),
        .o_stall       (stall),
        .o_error       (error),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_be      (mem_be),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .i_mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected values for the current cycle, written only by the stimulus process.
    logic        chk_en, chk_bus, chk_rd, chk_zero, txn_start, txn_end;
    logic        exp_stall, exp_req, exp_err, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;

    typedef struct {
        int          stalls;
        int          reqs;
        int          errs;
        bit          rd_en;
        logic [31:0] rd;
        bit          bus_en;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } pin_t;
    pin_t pin;

    // Written only by the compare process.
    int          n_pass, n_total;
    int          c_stall, c_req, c_err;
    logic [31:0] obs_rd, obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (txn_start) begin
            c_stall = 0;
            c_req   = 0;
            c_err   = 0;
        end
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            chk("error", 32'(error), 32'(exp_err));
            if (chk_bus) begin
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", 32'(mem_be), 32'(exp_be));
                chk("mem_wdata", mem_wdata, exp_wdata);
                obs_we    = mem_we;
                obs_addr  = mem_addr;
                obs_be    = mem_be;
                obs_wdata = mem_wdata;
            end
            if (chk_rd) begin
                chk("read_data", read_data, exp_rd);
                obs_rd = read_data;
            end
            if (chk_zero) begin
                chk("rst_mem_we", 32'(mem_we), 32'h0);
                chk("rst_mem_addr", mem_addr, 32'h0);
                chk("rst_mem_be", 32'(mem_be), 32'h0);
                chk("rst_mem_wdata", mem_wdata, 32'h0);
            end
        end
        c_stall += int'(stall);
        c_req   += int'(mem_req);
        c_err   += int'(error);
        if (txn_end) begin
            if (pin.stalls >= 0) chk("pin_stall_cycles", 32'(c_stall), 32'(pin.stalls));
            if (pin.reqs >= 0)   chk("pin_req_cycles", 32'(c_req), 32'(pin.reqs));
            if (pin.errs >= 0)   chk("pin_error_pulses", 32'(c_err), 32'(pin.errs));
            if (pin.rd_en)       chk("pin_read_data", obs_rd, pin.rd);
            if (pin.bus_en) begin
                chk("pin_mem_addr", obs_addr, pin.addr);
                chk("pin_mem_be", 32'(obs_be), 32'(pin.be));
                chk("pin_mem_wdata", obs_wdata, pin.wdata);
                chk("pin_mem_we", 32'(obs_we), 32'(pin.we));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pin(input int stalls, input int reqs, input int errs,
                           input bit rd_en, input logic [31:0] rd,
                           input bit bus_en, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic we);
        pin.stalls = stalls;
        pin.reqs   = reqs;
        pin.errs   = errs;
        pin.rd_en  = rd_en;
        pin.rd     = rd;
        pin.bus_en = bus_en;
        pin.addr   = addr;
        pin.be     = be;
        pin.wdata  = wdata;
        pin.we     = we;
    endtask

    // One command from the memory stage; ack_k = REQ cycle carrying mem_ack (0 = never).
    task automatic run(input logic rd, input logic wr, input logic bt,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdat, input int ack_k);
        logic       legal;
        int         n;
        logic [1:0] lane;
        lane  = addr[1:0];
        legal = !(rd && wr) && (bt || lane == 2'b00);
        n     = (ack_k > 0) ? ack_k : TMO;

        read_cmd   = rd;
        write_cmd  = wr;
        byte_acc   = bt;
        address    = addr;
        write_data = wd;
        exp_we     = wr;
        exp_addr   = addr & 32'hFFFF_FFFC;
        exp_be     = bt ? (4'b0001 << lane) : 4'hF;
        exp_wdata  = bt ? {4{wd[7:0]}} : wd;
        exp_rd     = (ack_k == 0) ? 32'h0 : (bt ? ((rdat >> (8 * lane)) & 32'hFF) : rdat);

        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0;
        chk_bus = 1'b0; chk_rd = 1'b0; chk_zero = 1'b0; chk_en = 1'b1;
        txn_start = 1'b1;
        tick();
        txn_start = 1'b0;

        if (legal) begin
            for (int c = 1; c <= n; c++) begin
                exp_req   = 1'b1;
                chk_bus   = 1'b1;
                mem_ack   = (c == ack_k);
                mem_rdata = (c == ack_k) ? rdat : ~rdat;
                tick();
            end
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        // Release cycle: command still held by the pipeline, must not be reissued.
        exp_req   = 1'b0;
        chk_bus   = 1'b0;
        exp_stall = 1'b0;
        exp_err   = !legal || (ack_k == 0);
        chk_rd    = legal && ((ack_k == 0) || !wr);
        tick();

        read_cmd  = 1'b0;
        write_cmd = 1'b0;
        exp_err   = 1'b0;
        chk_rd    = 1'b0;
        txn_end   = 1'b1;
        tick();
        txn_end   = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        c_stall = 0; c_req = 0; c_err = 0;
        obs_rd = '0; obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0;
        rst = 1'b1;
        read_cmd = 1'b0; write_cmd = 1'b0; byte_acc = 1'b0;
        address = '0; write_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        txn_start = 1'b0; txn_end = 1'b0;
        set_pin(-1, -1, -1, 0, '0, 0, '0, '0, '0, 1'b0);

        exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
        exp_addr = '0; exp_be = '0; exp_wdata = '0; exp_rd = '0;
        chk_en = 1'b1; chk_bus = 1'b0; chk_rd = 1'b1; chk_zero = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_zero = 1'b0;
        chk_rd = 1'b0;
        tick();

        set_pin(4, 3, 0, 1, 32'hDEADBEEF, 1, 32'h100, 4'hF, 32'h0, 1'b0);
        run(1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3);

        set_pin(2, 1, 0, 0, '0, 1, 32'h200, 4'b1000, 32'h78787878, 1'b1);
        run(0, 1, 1, 32'h203, 32'h12345678, 32'h0, 1);

        set_pin(3, 2, 0, 1, 32'h000000BB, 1, 32'h400, 4'b0100, 32'h0, 1'b0);
        run(1, 0, 1, 32'h402, 32'h0, 32'hAABBCCDD, 2);

        set_pin(2, 1, 0, 1, 32'h000000CC, -1 < 0, 32'h400, 4'b0010, 32'h0, 1'b0);
        run(1, 0, 1, 32'h401, 32'h0, 32'hAABBCCDD, 1);

        set_pin(2, 1, 0, 1, 32'h000000AA, 1, 32'h400, 4'b1000, 32'h0, 1'b0);
        run(1, 0, 1, 32'h403, 32'h0, 32'hAABBCCDD, 1);

        set_pin(3, 2, 0, 1, 32'h000000DD, 1, 32'h400, 4'b0001, 32'h0, 1'b0);
        run(1, 0, 1, 32'h400, 32'h0, 32'hAABBCCDD, 2);

        set_pin(2, 1, 0, 0, '0, 1, 32'h10, 4'b0001, 32'hA5A5A5A5, 1'b1);
        run(0, 1, 1, 32'h10, 32'hFFFF_FFA5, 32'h0, 1);

        set_pin(6, 5, 0, 0, '0, 1, 32'h300, 4'hF, 32'hCAFEF00D, 1'b1);
        run(0, 1, 0, 32'h300, 32'hCAFEF00D, 32'h0, 5);

        set_pin(1, 0, 1, 0, '0, 0, '0, '0, '0, 1'b0);
        run(1, 0, 0, 32'h101, 32'h0, 32'h0, 1);

        set_pin(1, 0, 1, 0, '0, 0, '0, '0, '0, 1'b0);
        run(1, 1, 0, 32'h200, 32'h55, 32'h0, 1);

        set_pin(65, 64, 1, 1, 32'h0, 1, 32'h600, 4'hF, 32'h0, 1'b0);
        run(1, 0, 0, 32'h600, 32'h0, 32'h12345678, 0);

        // Late acks after the timeout must be ignored.
        for (int i = 0; i < 3; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h0BAD0BAD;
            tick();
            mem_ack   = 1'b0;
            tick();
        end
        mem_rdata = '0;

        set_pin(64, 63, 0, 1, 32'h87654321, 1, 32'h700, 4'hF, 32'h0, 1'b0);
        run(1, 0, 0, 32'h700, 32'h0, 32'h87654321, 63);

        // Reset in the middle of an open request.
        read_cmd = 1'b1; byte_acc = 1'b0; address = 32'h500; write_data = 32'h0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0;
        exp_we = 1'b0; exp_addr = 32'h500; exp_be = 4'hF; exp_wdata = 32'h0;
        tick();
        exp_req = 1'b1; chk_bus = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        exp_stall = 1'b0; exp_req = 1'b0; chk_bus = 1'b0;
        chk_zero = 1'b1; chk_rd = 1'b1; exp_rd = 32'h0;
        tick();
        read_cmd = 1'b0;
        tick();
        rst = 1'b0;
        chk_zero = 1'b0; chk_rd = 1'b0;
        tick();

        set_pin(3, 2, 0, 1, 32'h0F0E0D0C, 1, 32'h504, 4'hF, 32'h0, 1'b0);
        run(1, 0, 0, 32'h504, 32'h0, 32'h0F0E0D0C, 2);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
